// File: rtl/cksum_arbiter_pkg.sv
// Shared definitions for the checksum-engine arbiter and its round-robin picker.
// State encodings, bus widths and the empty-field checksum value live here.
package cksum_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic TRUE        = 1'b1;
    localparam logic FALSE       = 1'b0;
    localparam logic RST_ENABLED = 1'b1;

    localparam logic [DATA_WIDTH-1:0] ZERO_WORD   = '0;
    localparam logic [15:0]           EMPTY_CKSUM = 16'hFFFF;

    typedef enum logic [1:0] {
        CKA_IDLE    = 2'd0,
        CKA_START   = 2'd1,
        CKA_WAIT    = 2'd2,
        CKA_RELEASE = 2'd3
    } cka_state_t;

endpackage

// File: rtl/cksum_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after ptr wins.
// Shared by the arbiters that front single-instance resources.
module rr_pick
    import cksum_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [IW-1:0] cand [N];
    logic [N-1:0]  rot;

    // cand[gi] is the requester examined at priority position gi.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum      = {1'b0, ptr} + (IW+1)'(gi);
            assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = FALSE;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = TRUE;
                idx   = cand[i];
            end
        end
    end

    assign onehot = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/cksum_arbiter.sv
// Round-robin owner of the single checksum engine: latches the winner's field,
// runs the level start/ready handshake and aborts the engine on a watchdog expiry.
module cksum_arbiter
    import cksum_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] len_i,
    output logic [N_REQ-1:0]            done_o,
    output logic [N_REQ-1:0]            err_o,
    output logic [15:0]                 val_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        busy_o,
    output logic                        eng_start_o,
    output logic                        eng_rst_o,
    output logic [ADDR_WIDTH-1:0]       eng_addr_o,
    output logic [DATA_WIDTH-1:0]       eng_len_o,
    input  logic                        eng_ready_i,
    input  logic [15:0]                 eng_val_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    cka_state_t            state_reg, state_next;
    logic [IW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [N_REQ-1:0]      grant_reg, grant_next;
    logic [N_REQ-1:0]      done_reg, done_next;
    logic [N_REQ-1:0]      err_reg, err_next;
    logic [15:0]           val_reg, val_next;
    logic                  eng_start_reg, eng_start_next;
    logic                  eng_rst_reg, eng_rst_next;
    logic [ADDR_WIDTH-1:0] eng_addr_reg, eng_addr_next;
    logic [DATA_WIDTH-1:0] eng_len_reg, eng_len_next;
    logic [CW-1:0]         cnt_reg, cnt_next;

    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic [N_REQ-1:0]      pick_onehot;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_len;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req    (req_i),
        .ptr    (rr_ptr_reg),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign pick_addr = addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign pick_len  = len_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            state_reg     <= CKA_IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
            err_reg       <= '0;
            val_reg       <= '0;
            eng_start_reg <= FALSE;
            eng_rst_reg   <= FALSE;
            eng_addr_reg  <= '0;
            eng_len_reg   <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            val_reg       <= val_next;
            eng_start_reg <= eng_start_next;
            eng_rst_reg   <= eng_rst_next;
            eng_addr_reg  <= eng_addr_next;
            eng_len_reg   <= eng_len_next;
            cnt_reg       <= cnt_next;
        end
    end

    // eng_start is registered from the next state so it is high during START and
    // WAIT, and low for the RELEASE cycle that lets the engine return to FREE.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        done_next      = '0;
        err_next       = '0;
        val_next       = val_reg;
        eng_start_next = eng_start_reg;
        eng_rst_next   = FALSE;
        eng_addr_next  = eng_addr_reg;
        eng_len_next   = eng_len_reg;
        cnt_next       = cnt_reg;
        unique case (state_reg)
            CKA_IDLE: begin
                eng_start_next = FALSE;
                if (pick_valid) begin
                    grant_next    = pick_onehot;
                    eng_addr_next = pick_addr;
                    eng_len_next  = pick_len;
                    rr_ptr_next   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (pick_len != ZERO_WORD) begin
                        eng_start_next = TRUE;
                        state_next     = CKA_START;
                    end else begin
                        done_next  = pick_onehot;
                        val_next   = EMPTY_CKSUM;
                        state_next = CKA_RELEASE;
                    end
                end
            end
            CKA_START: begin
                cnt_next       = '0;
                eng_start_next = TRUE;
                state_next     = CKA_WAIT;
            end
            CKA_WAIT: begin
                eng_start_next = TRUE;
                if (eng_ready_i) begin
                    val_next       = eng_val_i;
                    done_next      = grant_reg;
                    eng_start_next = FALSE;
                    state_next     = CKA_RELEASE;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    val_next       = '0;
                    err_next       = grant_reg;
                    eng_rst_next   = TRUE;
                    eng_start_next = FALSE;
                    state_next     = CKA_RELEASE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CKA_RELEASE: begin
                grant_next     = '0;
                eng_start_next = FALSE;
                state_next     = CKA_IDLE;
            end
            default: state_next = CKA_IDLE;
        endcase
    end

    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign val_o       = val_reg;
    assign grant_o     = grant_reg;
    assign busy_o      = (state_reg != CKA_IDLE);
    assign eng_start_o = eng_start_reg;
    assign eng_rst_o   = eng_rst_reg;
    assign eng_addr_o  = eng_addr_reg;
    assign eng_len_o   = eng_len_reg;

endmodule

// File: tb/tb_cksum_arbiter.sv
// Directed bench for cksum_arbiter: grant order, handshake latency, zero-length,
// watchdog abort, stale ready and mid-operation reset.
module tb_cksum_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] len_i;
    logic [N-1:0]    done_o, err_o, grant_o;
    logic [15:0]     val_o;
    logic            busy_o, eng_start_o, eng_rst_o;
    logic [AW-1:0]   eng_addr_o;
    logic [DW-1:0]   eng_len_o;
    logic            eng_ready_i;
    logic [15:0]     eng_val_i;

    logic [AW-1:0] tb_addr [N];
    logic [DW-1:0] tb_len  [N];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fields
            assign addr_i[gi*AW +: AW] = tb_addr[gi];
            assign len_i[gi*DW +: DW]  = tb_len[gi];
        end
    endgenerate

    cksum_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .len_i       (len_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .val_o       (val_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .eng_start_o (eng_start_o),
        .eng_rst_o   (eng_rst_o),
        .eng_addr_o  (eng_addr_o),
        .eng_len_o   (eng_len_o),
        .eng_ready_i (eng_ready_i),
        .eng_val_i   (eng_val_i)
    );

    // Offsets k count cycles from the first cycle grant_o is visible (START, or
    // RELEASE for a zero-length field). The ready level driven at cycle k is
    // sampled on the edge ending that cycle.
    task automatic run_op(input string name, input logic [N-1:0] req, input logic [N-1:0] exp_grant,
                          input int rdy_at, input bit stale, input logic [15:0] eval,
                          input int exp_off, input bit exp_err, input logic [15:0] exp_val,
                          input bit keep_req);
        bit got;
        int k;
        int e;
        logic [N-1:0] exp_done, exp_errv;
        req_i = req;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant_o != '0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL %s grant_wait: no grant within 20 cycles, required %b", name, exp_grant);
            req_i = '0;
            return;
        end
        checks++;
        if (grant_o !== exp_grant) begin
            fails++;
            $display("FAIL %s grant: got %b required %b", name, grant_o, exp_grant);
        end
        e = 0;
        for (int i = 0; i < N; i++) if (exp_grant[i]) e = i;
        checks++;
        if (eng_addr_o !== tb_addr[e] || eng_len_o !== tb_len[e]) begin
            fails++;
            $display("FAIL %s field: got addr=%h len=%0d required addr=%h len=%0d",
                     name, eng_addr_o, eng_len_o, tb_addr[e], tb_len[e]);
        end
        k = 0;
        got = 1'b0;
        while (!got && k < 64) begin
            if (done_o != '0 || err_o != '0) begin
                got = 1'b1;
            end else begin
                checks++;
                if (eng_start_o !== 1'b1) begin
                    fails++;
                    $display("FAIL %s start_level: got %b required 1 at offset %0d", name, eng_start_o, k);
                end
                eng_val_i   = eval;
                eng_ready_i = (stale && k == 0) || (k >= rdy_at);
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL %s completion: no done/err within 64 cycles", name);
        end else begin
            exp_done = exp_err ? '0 : exp_grant;
            exp_errv = exp_err ? exp_grant : '0;
            checks++;
            if (k !== exp_off) begin
                fails++;
                $display("FAIL %s latency: got offset %0d required %0d", name, k, exp_off);
            end
            checks++;
            if (done_o !== exp_done || err_o !== exp_errv) begin
                fails++;
                $display("FAIL %s pulse: got done=%b err=%b required done=%b err=%b",
                         name, done_o, err_o, exp_done, exp_errv);
            end
            checks++;
            if (val_o !== exp_val) begin
                fails++;
                $display("FAIL %s val: got %h required %h", name, val_o, exp_val);
            end
            checks++;
            if (eng_start_o !== 1'b0 || eng_rst_o !== exp_err || grant_o !== exp_grant || busy_o !== 1'b1) begin
                fails++;
                $display("FAIL %s release: got start=%b eng_rst=%b grant=%b busy=%b required 0 %b %b 1",
                         name, eng_start_o, eng_rst_o, grant_o, busy_o, exp_err, exp_grant);
            end
        end
        $display("op %s: grant=%b offset=%0d done=%b err=%b val=%h", name, grant_o, k, done_o, err_o, val_o);
        eng_ready_i = 1'b0;
        if (!keep_req) req_i = '0;
        @(negedge clk);
        checks++;
        if (done_o !== '0 || err_o !== '0 || grant_o !== '0 || eng_rst_o !== 1'b0 ||
            eng_start_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_gap: got done=%b err=%b grant=%b eng_rst=%b start=%b busy=%b required all 0",
                     name, done_o, err_o, grant_o, eng_rst_o, eng_start_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_i = 4'b1111;
        eng_ready_i = 1'b1;
        eng_val_i = 16'hDEAD;
        repeat (3) @(negedge clk);
        checks++;
        if (done_o !== '0 || err_o !== '0 || grant_o !== '0 || val_o !== '0 || busy_o !== 1'b0 ||
            eng_start_o !== 1'b0 || eng_rst_o !== 1'b0 || eng_addr_o !== '0 || eng_len_o !== '0) begin
            fails++;
            $display("FAIL reset_state: got done=%b err=%b grant=%b val=%h busy=%b start=%b eng_rst=%b addr=%h len=%h required all 0",
                     done_o, err_o, grant_o, val_o, busy_o, eng_start_o, eng_rst_o, eng_addr_o, eng_len_o);
        end
        $display("op reset: grant=%b busy=%b val=%h", grant_o, busy_o, val_o);
        req_i = '0;
        eng_ready_i = 1'b0;
        eng_val_i = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        run_op("fair0", 4'b1111, 4'b0001, 2, 1'b0, 16'h1000, 3, 1'b0, 16'h1000, 1'b1);
        run_op("fair1", 4'b1111, 4'b0010, 2, 1'b0, 16'h1001, 3, 1'b0, 16'h1001, 1'b1);
        run_op("fair2", 4'b1111, 4'b0100, 2, 1'b0, 16'h1002, 3, 1'b0, 16'h1002, 1'b1);
        run_op("fair3", 4'b1111, 4'b1000, 2, 1'b0, 16'h1003, 3, 1'b0, 16'h1003, 1'b1);
        run_op("fair4", 4'b1111, 4'b0001, 1, 1'b0, 16'h1004, 2, 1'b0, 16'h1004, 1'b0);
    endtask

    task automatic test_single();
        run_op("single", 4'b0001, 4'b0001, 13, 1'b0, 16'hB861, 14, 1'b0, 16'hB861, 1'b0);
    endtask

    task automatic test_zero_len();
        tb_len[2] = '0;
        run_op("zero_len", 4'b0100, 4'b0100, 1000, 1'b0, 16'h0000, 0, 1'b0, 16'hFFFF, 1'b0);
        tb_len[2] = 32'd36;
    endtask

    task automatic test_timeout();
        run_op("timeout", 4'b0010, 4'b0010, 1000, 1'b0, 16'h7777, 17, 1'b1, 16'h0000, 1'b0);
        run_op("after_to", 4'b0010, 4'b0010, 3, 1'b0, 16'h1234, 4, 1'b0, 16'h1234, 1'b0);
    endtask

    task automatic test_stale_ready();
        eng_ready_i = 1'b1;
        eng_val_i   = 16'hBAD0;
        run_op("stale", 4'b1000, 4'b1000, 4, 1'b1, 16'h5A5A, 5, 1'b0, 16'h5A5A, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        bit got;
        req_i = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant_o != '0) got = 1'b1;
        end
        checks++;
        if (!got || grant_o !== 4'b0100) begin
            fails++;
            $display("FAIL midrst_grant: got %b required 0100", grant_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (done_o !== '0 || err_o !== '0 || grant_o !== '0 || val_o !== '0 || busy_o !== 1'b0 ||
            eng_start_o !== 1'b0 || eng_rst_o !== 1'b0 || eng_addr_o !== '0 || eng_len_o !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: got done=%b err=%b grant=%b val=%h busy=%b start=%b eng_rst=%b required all 0",
                     done_o, err_o, grant_o, val_o, busy_o, eng_start_o, eng_rst_o);
        end
        $display("op midrst: grant=%b busy=%b", grant_o, busy_o);
        rst = 1'b0;
        req_i = '0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (done_o !== '0 || err_o !== '0 || busy_o !== 1'b0) begin
                fails++;
                $display("FAIL midrst_quiet: got done=%b err=%b busy=%b required 0 0 0", done_o, err_o, busy_o);
            end
        end
        run_op("post_rst_ptr", 4'b1001, 4'b0001, 2, 1'b0, 16'h0F0F, 3, 1'b0, 16'h0F0F, 1'b0);
        run_op("post_rst_r3", 4'b1000, 4'b1000, 1, 1'b0, 16'hC3C3, 2, 1'b0, 16'hC3C3, 1'b0);
    endtask

    initial begin
        tb_addr[0] = 32'h0000_0040; tb_len[0] = 32'd20;
        tb_addr[1] = 32'h0000_0140; tb_len[1] = 32'd28;
        tb_addr[2] = 32'h0000_0240; tb_len[2] = 32'd36;
        tb_addr[3] = 32'h0000_0340; tb_len[3] = 32'd64;
        rst = 1'b1;
        req_i = '0;
        eng_ready_i = 1'b0;
        eng_val_i = '0;
        test_reset();
        test_fairness();
        test_single();
        test_zero_len();
        test_timeout();
        test_stale_ready();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
